// File: rtl/rv_iopmp_entry_scanner_if.sv
// Request/response channel between a requester and the IOPMP entry scanner.
// slave: scanner side, master: requester side.
interface rv_iopmp_entry_scanner_if #(
  parameter int NUM_ENTRY  = 16,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  localparam int IDX_W = $clog2(NUM_ENTRY);
  localparam int NB_W  = $clog2(DATA_WIDTH/8) + 1;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [NB_W-1:0]       req_num_bytes_i;
  logic [2:0]            req_type_i;
  logic [IDX_W-1:0]      entry_first_i;
  logic [IDX_W-1:0]      entry_last_i;
  logic [IDX_W:0]        prio_entry_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic                  rsp_allow_o;
  logic [2:0]            rsp_err_type_o;
  logic [IDX_W-1:0]      rsp_entry_idx_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_num_bytes_i, req_type_i,
           entry_first_i, entry_last_i, prio_entry_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_allow_o, rsp_err_type_o, rsp_entry_idx_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_num_bytes_i, req_type_i,
           entry_first_i, entry_last_i, prio_entry_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_allow_o, rsp_err_type_o, rsp_entry_idx_o
  );
endinterface

// File: rtl/rv_iopmp_entry_scanner.sv
// Sequential IOPMP priority resolver: walks one entry per cycle and folds analyzer results into one response.
// Optional RV_IOPMP_SCAN_STATS_EN adds scan_cycles_o (SCAN cycles of the last completed request).
module rv_iopmp_entry_scanner #(
  parameter int NUM_ENTRY  = 16,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  localparam int IDX_W     = $clog2(NUM_ENTRY),
  localparam int NB_W      = $clog2(DATA_WIDTH/8) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  rv_iopmp_entry_scanner_if.slave bus,
  output logic [IDX_W-1:0]      entry_idx_o,
  output logic [ADDR_WIDTH-1:0] chk_addr_o,
  output logic [NB_W-1:0]       chk_num_bytes_o,
  output logic [2:0]            chk_type_o,
  input  logic                  entry_match_i,
  input  logic                  entry_allow_i,
  input  logic [2:0]            entry_perm_i
`ifdef RV_IOPMP_SCAN_STATS_EN
  ,
  output logic [IDX_W:0]        scan_cycles_o
`endif
);

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_READ    = 3'd1;
  localparam logic [2:0] ERR_WRITE   = 3'd2;
  localparam logic [2:0] ERR_EXEC    = 3'd3;
  localparam logic [2:0] ERR_PARTIAL = 3'd4;
  localparam logic [2:0] ERR_NO_HIT  = 3'd5;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [NB_W-1:0]       nb_q;
  logic [2:0]            type_q;
  logic [IDX_W-1:0]      idx_q, last_q;
  logic [IDX_W:0]        prio_q;
  logic                  deny_found_q;
  logic [2:0]            deny_err_q;
  logic [IDX_W-1:0]      deny_idx_q;
  logic                  rsp_allow_q;
  logic [2:0]            rsp_err_q;
  logic [IDX_W-1:0]      rsp_idx_q;

  logic                  is_prio, np_deny, decide, dec_allow;
  logic [2:0]            cur_err, dec_err;
  logic [IDX_W-1:0]      dec_idx;

  // Missing rights are reported lowest bit first; no missing right means the analyzer refused on size.
  function automatic logic [2:0] perm_err(input logic [2:0] t, input logic [2:0] p);
    logic [2:0] miss;
    miss = t & ~p;
    if (miss[0])      return ERR_READ;
    else if (miss[1]) return ERR_WRITE;
    else if (miss[2]) return ERR_EXEC;
    else              return ERR_PARTIAL;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A non-priority refusal with full rights is only a partial hit and is not recorded as a deny.
  always_comb begin
    state_d   = state_q;
    is_prio   = ({1'b0, idx_q} < prio_q);
    cur_err   = perm_err(type_q, entry_perm_i);
    np_deny   = 1'b0;
    decide    = 1'b0;
    dec_allow = 1'b0;
    dec_err   = ERR_NONE;
    dec_idx   = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i)
          state_d = (bus.entry_first_i > bus.entry_last_i) ? RESP : SCAN;
      end
      SCAN: begin
        np_deny = entry_match_i && !entry_allow_i && !is_prio && (cur_err != ERR_PARTIAL);
        if (entry_match_i && is_prio) begin
          decide    = 1'b1;
          dec_allow = entry_allow_i;
          dec_err   = entry_allow_i ? ERR_NONE : cur_err;
          dec_idx   = idx_q;
        end else if (entry_match_i && entry_allow_i) begin
          decide    = 1'b1;
          dec_allow = 1'b1;
          dec_idx   = idx_q;
        end else if (idx_q == last_q) begin
          decide = 1'b1;
          if (deny_found_q) begin
            dec_err = deny_err_q;
            dec_idx = deny_idx_q;
          end else if (np_deny) begin
            dec_err = cur_err;
            dec_idx = idx_q;
          end else begin
            dec_err = ERR_NO_HIT;
          end
        end
        if (decide) state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_o     = (state_q == IDLE);
    bus.rsp_valid_o     = (state_q == RESP);
    bus.rsp_allow_o     = rsp_allow_q;
    bus.rsp_err_type_o  = rsp_err_q;
    bus.rsp_entry_idx_o = rsp_idx_q;
    entry_idx_o         = idx_q;
    chk_addr_o          = addr_q;
    chk_num_bytes_o     = nb_q;
    chk_type_o          = type_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q       <= '0;
      nb_q         <= '0;
      type_q       <= '0;
      idx_q        <= '0;
      last_q       <= '0;
      prio_q       <= '0;
      deny_found_q <= 1'b0;
      deny_err_q   <= ERR_NONE;
      deny_idx_q   <= '0;
      rsp_allow_q  <= 1'b0;
      rsp_err_q    <= ERR_NONE;
      rsp_idx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i) begin
            addr_q       <= bus.req_addr_i;
            nb_q         <= bus.req_num_bytes_i;
            type_q       <= bus.req_type_i;
            idx_q        <= bus.entry_first_i;
            last_q       <= bus.entry_last_i;
            prio_q       <= bus.prio_entry_i;
            deny_found_q <= 1'b0;
            deny_err_q   <= ERR_NONE;
            deny_idx_q   <= '0;
            if (bus.entry_first_i > bus.entry_last_i) begin
              rsp_allow_q <= 1'b0;
              rsp_err_q   <= ERR_NO_HIT;
              rsp_idx_q   <= '0;
            end
          end
        end
        SCAN: begin
          if (decide) begin
            rsp_allow_q <= dec_allow;
            rsp_err_q   <= dec_err;
            rsp_idx_q   <= dec_idx;
          end else begin
            if (np_deny && !deny_found_q) begin
              deny_found_q <= 1'b1;
              deny_err_q   <= cur_err;
              deny_idx_q   <= idx_q;
            end
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RV_IOPMP_SCAN_STATS_EN
  logic [IDX_W:0] cnt_q, stats_q;

  // cnt_q counts SCAN cycles already completed; the deciding cycle adds one more.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      stats_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i) begin
            cnt_q <= '0;
            if (bus.entry_first_i > bus.entry_last_i) stats_q <= '0;
          end
        end
        SCAN: begin
          cnt_q <= cnt_q + (IDX_W+1)'(1);
          if (decide) stats_q <= cnt_q + (IDX_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

  assign scan_cycles_o = stats_q;
`endif

endmodule

// File: tb/tb_rv_iopmp_entry_scanner.sv
// Scoreboard bench for rv_iopmp_entry_scanner with a table-driven analyzer model.
module tb_rv_iopmp_entry_scanner;
  localparam int NUM_ENTRY  = 16;
  localparam int ADDR_WIDTH = 64;
  localparam int DATA_WIDTH = 64;
  localparam int IDX_W      = 4;
  localparam int NB_W       = 4;
  localparam logic [2:0] R = 3'b001, W = 3'b010, X = 3'b100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv_iopmp_entry_scanner_if #(.NUM_ENTRY(NUM_ENTRY), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus();

  logic [IDX_W-1:0]      entry_idx;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic [NB_W-1:0]       chk_nb;
  logic [2:0]            chk_type;
  logic                  entry_match, entry_allow;
  logic [2:0]            entry_perm;
  logic [NUM_ENTRY-1:0]  match_vec, allow_vec;
  logic [2:0]            perm_tbl [NUM_ENTRY];
`ifdef RV_IOPMP_SCAN_STATS_EN
  logic [IDX_W:0]        scan_cycles;
`endif

  assign entry_match = match_vec[entry_idx];
  assign entry_allow = allow_vec[entry_idx];
  assign entry_perm  = perm_tbl[entry_idx];

  rv_iopmp_entry_scanner #(.NUM_ENTRY(NUM_ENTRY), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .bus             (bus),
    .entry_idx_o     (entry_idx),
    .chk_addr_o      (chk_addr),
    .chk_num_bytes_o (chk_nb),
    .chk_type_o      (chk_type),
    .entry_match_i   (entry_match),
    .entry_allow_i   (entry_allow),
    .entry_perm_i    (entry_perm)
`ifdef RV_IOPMP_SCAN_STATS_EN
    ,
    .scan_cycles_o   (scan_cycles)
`endif
  );

  typedef struct {
    logic                  allow;
    logic [2:0]            err;
    logic [IDX_W-1:0]      idx;
    int                    n;
    logic [IDX_W-1:0]      first;
    logic [ADDR_WIDTH-1:0] addr;
    logic [NB_W-1:0]       nb;
    logic [2:0]            typ;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic clear_tbl();
    match_vec = '0;
    allow_vec = '0;
    for (int i = 0; i < NUM_ENTRY; i++) perm_tbl[i] = 3'b000;
  endtask

  task automatic set_entry(input int i, input logic m, input logic a, input logic [2:0] p);
    match_vec[i] = m;
    allow_vec[i] = a;
    perm_tbl[i]  = p;
  endtask

  task automatic issue_req(input logic [IDX_W-1:0] first, input logic [IDX_W-1:0] last,
                           input logic [IDX_W:0] prio, input logic [2:0] typ,
                           input logic [ADDR_WIDTH-1:0] addr, input logic [NB_W-1:0] nb,
                           input logic e_allow, input logic [2:0] e_err,
                           input logic [IDX_W-1:0] e_idx, input int e_n);
    exp_t e;
    e.allow = e_allow; e.err = e_err; e.idx = e_idx; e.n = e_n;
    e.first = first; e.addr = addr; e.nb = nb; e.typ = typ;
    exp_q.push_back(e);
    @(negedge clk);
    total++;
    if (bus.req_ready_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL req_ready_idle got=%b want=1", bus.req_ready_o);
    end
    bus.req_valid_i     = 1'b1;
    bus.entry_first_i   = first;
    bus.entry_last_i    = last;
    bus.prio_entry_i    = prio;
    bus.req_type_i      = typ;
    bus.req_addr_i      = addr;
    bus.req_num_bytes_i = nb;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int hold);
    exp_t e;
    int n;
    bit got;
    n = 0;
    got = 0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_empty got=0 want>0");
      return;
    end
    e = exp_q.pop_front();
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (bus.rsp_valid_o === 1'b1) got = 1;
      else begin
        total++;
        if (int'(entry_idx) !== int'(e.first) + n) begin
          bad++;
          $display("[TB] FAIL scan_idx got=%0d want=%0d", entry_idx, int'(e.first) + n);
        end
        n++;
      end
    end
    if (!got) begin
      bad++;
      $display("[TB] FAIL rsp_timeout got=no_rsp want=rsp_valid");
      return;
    end
    if (n !== e.n) begin
      bad++;
      $display("[TB] FAIL scan_count got=%0d want=%0d", n, e.n);
    end
    total++;
    if (bus.rsp_allow_o !== e.allow) begin
      bad++;
      $display("[TB] FAIL rsp_allow got=%b want=%b", bus.rsp_allow_o, e.allow);
    end
    total++;
    if (bus.rsp_err_type_o !== e.err) begin
      bad++;
      $display("[TB] FAIL rsp_err got=%0d want=%0d", bus.rsp_err_type_o, e.err);
    end
    total++;
    if (bus.rsp_entry_idx_o !== e.idx) begin
      bad++;
      $display("[TB] FAIL rsp_idx got=%0d want=%0d", bus.rsp_entry_idx_o, e.idx);
    end
    total++;
    if (chk_addr !== e.addr || chk_nb !== e.nb || chk_type !== e.typ) begin
      bad++;
      $display("[TB] FAIL chk_fields got=%h/%0d/%0d want=%h/%0d/%0d",
               chk_addr, chk_nb, chk_type, e.addr, e.nb, e.typ);
    end
    total++;
    if (bus.req_ready_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL req_ready_resp got=%b want=0", bus.req_ready_o);
    end
`ifdef RV_IOPMP_SCAN_STATS_EN
    total++;
    if (int'(scan_cycles) !== e.n) begin
      bad++;
      $display("[TB] FAIL scan_cycles got=%0d want=%0d", scan_cycles, e.n);
    end
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_allow_o !== e.allow || bus.rsp_err_type_o !== e.err ||
          bus.rsp_entry_idx_o !== e.idx || bus.req_ready_o !== 1'b0 || chk_addr !== e.addr) begin
        bad++;
        $display("[TB] FAIL rsp_hold got=v%b a%b e%0d i%0d r%b want=v1 a%b e%0d i%0d r0",
                 bus.rsp_valid_o, bus.rsp_allow_o, bus.rsp_err_type_o, bus.rsp_entry_idx_o,
                 bus.req_ready_o, e.allow, e.err, e.idx);
      end
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rsp_release got=v%b r%b want=v0 r1", bus.rsp_valid_o, bus.req_ready_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_handshake got=r%b v%b want=r1 v0", bus.req_ready_o, bus.rsp_valid_o);
    end
    total++;
    if (bus.rsp_allow_o !== 1'b0 || bus.rsp_err_type_o !== 3'd0 || bus.rsp_entry_idx_o !== '0) begin
      bad++;
      $display("[TB] FAIL reset_rsp got=a%b e%0d i%0d want=a0 e0 i0",
               bus.rsp_allow_o, bus.rsp_err_type_o, bus.rsp_entry_idx_o);
    end
    total++;
    if (entry_idx !== '0 || chk_addr !== '0 || chk_nb !== '0 || chk_type !== '0) begin
      bad++;
      $display("[TB] FAIL reset_chk got=%0d/%h/%0d/%0d want=0/0/0/0", entry_idx, chk_addr, chk_nb, chk_type);
    end
`ifdef RV_IOPMP_SCAN_STATS_EN
    total++;
    if (scan_cycles !== '0) begin
      bad++;
      $display("[TB] FAIL reset_stats got=%0d want=0", scan_cycles);
    end
`endif
  endtask

  task automatic test_prio_allow();
    clear_tbl();
    set_entry(1, 1'b1, 1'b1, R);
    issue_req(4'd0, 4'd3, 5'd2, R, 64'h0000_1000, 4'd8, 1'b1, 3'd0, 4'd1, 2);
    wait_rsp(0);
  endtask

  task automatic test_prio_deny();
    clear_tbl();
    set_entry(0, 1'b1, 1'b0, W);
    issue_req(4'd0, 4'd3, 5'd4, R, 64'h0000_2000, 4'd4, 1'b0, 3'd1, 4'd0, 1);
    wait_rsp(0);
    clear_tbl();
    set_entry(1, 1'b1, 1'b0, R | W);
    issue_req(4'd1, 4'd3, 5'd4, X, 64'hdead_0000_0000_0040, 4'd2, 1'b0, 3'd3, 4'd1, 1);
    wait_rsp(0);
    clear_tbl();
    set_entry(0, 1'b1, 1'b0, 3'b000);
    issue_req(4'd0, 4'd2, 5'd1, R | W, 64'h0000_3000, 4'd1, 1'b0, 3'd1, 4'd0, 1);
    wait_rsp(0);
  endtask

  task automatic test_partial_hit();
    clear_tbl();
    set_entry(2, 1'b1, 1'b0, R | W | X);
    issue_req(4'd0, 4'd3, 5'd4, R, 64'h0000_4ffc, 4'd8, 1'b0, 3'd4, 4'd2, 3);
    wait_rsp(5);
  endtask

  task automatic test_nonprio();
    clear_tbl();
    set_entry(1, 1'b1, 1'b0, R);
    set_entry(4, 1'b1, 1'b1, R | W);
    issue_req(4'd0, 4'd5, 5'd0, W, 64'h0000_5000, 4'd8, 1'b1, 3'd0, 4'd4, 5);
    wait_rsp(0);
    set_entry(4, 1'b0, 1'b0, 3'b000);
    issue_req(4'd0, 4'd5, 5'd0, W, 64'h0000_5008, 4'd8, 1'b0, 3'd2, 4'd1, 6);
    wait_rsp(0);
    clear_tbl();
    set_entry(2, 1'b1, 1'b0, R);
    issue_req(4'd2, 4'd2, 5'd0, W, 64'h0000_6000, 4'd1, 1'b0, 3'd2, 4'd2, 1);
    wait_rsp(0);
    clear_tbl();
    set_entry(2, 1'b1, 1'b0, R);
    set_entry(3, 1'b1, 1'b1, W);
    issue_req(4'd0, 4'd5, 5'd2, W, 64'h0000_7000, 4'd2, 1'b1, 3'd0, 4'd3, 4);
    wait_rsp(0);
  endtask

  task automatic test_no_hit();
    clear_tbl();
    issue_req(4'd0, 4'd7, 5'd4, R, 64'h0000_8000, 4'd8, 1'b0, 3'd5, 4'd0, 8);
    wait_rsp(0);
    issue_req(4'd5, 4'd3, 5'd4, R, 64'h0000_8100, 4'd8, 1'b0, 3'd5, 4'd0, 0);
    wait_rsp(0);
    issue_req(4'd0, 4'd15, 5'd16, W, 64'h0000_8200, 4'd4, 1'b0, 3'd5, 4'd0, 16);
    wait_rsp(1);
  endtask

  task automatic test_back_to_back();
    clear_tbl();
    set_entry(0, 1'b1, 1'b1, R);
    set_entry(3, 1'b1, 1'b1, X);
    issue_req(4'd0, 4'd3, 5'd1, R, 64'h0000_9000, 4'd8, 1'b1, 3'd0, 4'd0, 1);
    wait_rsp(0);
    issue_req(4'd1, 4'd3, 5'd1, X, 64'h0000_9100, 4'd4, 1'b1, 3'd0, 4'd3, 3);
    wait_rsp(0);
  endtask

  task automatic test_reset_mid();
    clear_tbl();
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.entry_first_i = 4'd0; bus.entry_last_i = 4'd9;
    bus.prio_entry_i = 5'd0; bus.req_type_i = R; bus.req_addr_i = 64'haaaa; bus.req_num_bytes_i = 4'd8;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1 || entry_idx !== '0 || chk_addr !== '0) begin
      bad++;
      $display("[TB] FAIL reset_mid_scan got=v%b r%b i%0d a%h want=v0 r1 i0 a0",
               bus.rsp_valid_o, bus.req_ready_o, entry_idx, chk_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid_i = 1'b1; bus.entry_first_i = 4'd6; bus.entry_last_i = 4'd1;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_type_o !== 3'd5) begin
      bad++;
      $display("[TB] FAIL resp_before_reset got=v%b e%0d want=v1 e5", bus.rsp_valid_o, bus.rsp_err_type_o);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.rsp_err_type_o !== 3'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid_resp got=v%b r%b e%0d want=v0 r1 e0",
               bus.rsp_valid_o, bus.req_ready_o, bus.rsp_err_type_o);
    end
    @(negedge clk);
    rst = 1'b0;
    set_entry(2, 1'b1, 1'b1, R);
    issue_req(4'd0, 4'd4, 5'd0, R, 64'h0000_a000, 4'd8, 1'b1, 3'd0, 4'd2, 3);
    wait_rsp(0);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid_i = 1'b0; bus.req_addr_i = '0; bus.req_num_bytes_i = '0; bus.req_type_i = '0;
    bus.entry_first_i = '0; bus.entry_last_i = '0; bus.prio_entry_i = '0; bus.rsp_ready_i = 1'b0;
    clear_tbl();
    test_reset();
    test_prio_allow();
    test_prio_deny();
    test_partial_hit();
    test_nonprio();
    test_no_hit();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/rv_iopmp_entry_scanner.md
Name: rv_iopmp_entry_scanner

Overview:
- Sequential priority-resolution stage placed around the entry analyzer.
- Accepts one transaction check request at a time and steps an entry index across the memory-domain entry range, one entry per cycle.
- Drives the checked transaction to the analyzer and consumes its match/allow results.
- Resolves IOPMP priority/non-priority semantics into a single allow/deny response with error type and matching entry index.

Parameters:
- NUM_ENTRY, 16, number of entries in the table; IDX_W = $clog2(NUM_ENTRY).
- ADDR_WIDTH, 64, transaction address width.
- DATA_WIDTH, 64, bus data width; num_bytes width = $clog2(DATA_WIDTH/8)+1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  check request valid.
- req_ready_o  out  1  scanner can accept a request.
- req_addr_i  in  ADDR_WIDTH  transaction address.
- req_num_bytes_i  in  $clog2(DATA_WIDTH/8)+1  transaction byte count.
- req_type_i  in  3  rv_iopmp_pkg::access_t (bit0 R, bit1 W, bit2 X).
- entry_first_i  in  IDX_W  first entry of the domain range, sampled with the request.
- entry_last_i  in  IDX_W  last entry of the range (inclusive), sampled with the request.
- prio_entry_i  in  IDX_W+1  entries with index < prio_entry_i are priority entries.
- entry_idx_o  out  IDX_W  entry currently presented to the table/analyzer.
- chk_addr_o  out  ADDR_WIDTH  registered request address to the analyzer.
- chk_num_bytes_o  out  $clog2(DATA_WIDTH/8)+1  registered byte count.
- chk_type_o  out  3  registered access type.
- entry_match_i  in  1  analyzer match for entry_idx_o, same cycle.
- entry_allow_i  in  1  analyzer allow for entry_idx_o, same cycle.
- entry_perm_i  in  3  permissions of entry_idx_o.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  result consumed.
- rsp_allow_o  out  1  transaction permitted.
- rsp_err_type_o  out  3  0 none, 1 illegal read, 2 illegal write, 3 illegal exec, 4 partial hit on priority entry, 5 no hit.
- rsp_entry_idx_o  out  IDX_W  deciding entry (0 when err_type = 5).

Behaviour:
- Reset values: state IDLE; req_ready_o=1 (combinational from IDLE); rsp_valid_o, rsp_allow_o, rsp_err_type_o, rsp_entry_idx_o, entry_idx_o, all chk_* outputs = 0; internal hit flags cleared.
- FSM: IDLE, SCAN, RESP.
- IDLE: on req_valid_i, register request fields, first/last and prio; entry_idx = first; clear any_hit and deny_idx.
  - If first > last: go directly to RESP with no-hit.
  - Otherwise go to SCAN.
- SCAN, one entry per cycle, evaluated on current idx:
  - Priority entry (idx < prio) with match and allow: RESP, allow=1, err=0, idx.
  - Priority entry with match and no allow: RESP, allow=0, idx.
    - err=4 when (chk_type & perm) == chk_type.
    - Otherwise err = 1/2/3 by the lowest set bit of chk_type & ~perm (R before W before X).
  - Non-priority entry with match and allow: RESP, allow=1, idx.
  - Non-priority entry with match and no allow: record first such idx and err code (same rule, but 4 is never produced); continue.
  - idx == last with no decision: RESP.
    - If a recorded deny exists: allow=0 with recorded err/idx.
    - Otherwise err=5, idx=0.
  - Otherwise idx+1; wrap never occurs, because last ≤ NUM_ENTRY-1 bounds the scan.
- Latency: request accept to rsp_valid_o = (number of entries scanned) cycles, minimum 1. A decision on entry k registers at the end of that cycle.
- RESP: rsp_valid_o=1 with outputs held stable until rsp_ready_i. The cycle after the handshake, the FSM returns to IDLE.
- req_ready_o=1 only in IDLE, so there is no overlap between requests.
- chk_* outputs stay stable from acceptance through RESP.
- Response fields are registered and may change only on entering RESP.
- rst_i asserted mid-scan or mid-RESP: next cycle returns all state to IDLE/reset values. Any in-flight request is dropped with no response.

Optional Feature:
- RV_IOPMP_SCAN_STATS_EN.
- Defined: adds output scan_cycles_o [IDX_W:0], the number of SCAN cycles taken by the last completed request.
  - Updated on entering RESP; reset to 0.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- first=0, last=3, prio=2; entry1 matches with allow=1 -> rsp after 2 cycles, allow=1, err=0, idx=1.
- R request, prio=4; entry0 matches, allow=0, perm=W -> allow=0, err=1, idx=0; entries 1-3 never presented.
- Priority entry2 matches, allow=0, perm=RWX (size overflow) -> err=4, idx=2.
- prio=0, range 0..5; entry1 matches and denies (W request, perm=R), entry4 matches and allows -> allow=1, idx=4. Repeat with entry4 not matching -> allow=0, err=2, idx=1.
- No matches in 0..7 -> after 8 cycles allow=0, err=5, idx=0. first=5, last=3 -> rsp after 1 cycle with err=5.
- Hold rsp_ready_i=0 for 5 cycles -> outputs stable, req_ready_o=0. Assert rst_i during SCAN -> IDLE, rsp_valid_o=0, req_ready_o=1 next cycle.
